// File: rtl/tl_uh_pkg.sv
// Shared TL-UH definitions for the memory responder: opcodes, FSM states,
// the latched request record and the size-to-beats helper.
package tl_uh_pkg;

    localparam int unsigned BEAT_W = 5;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;
    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE,
        WBURST,
        WAIT,
        RESP
    } state_e;

    // Request fields captured on the first A beat.
    typedef struct packed {
        logic [2:0] opcode;
        logic [2:0] size;
        logic [3:0] source;
        logic       denied;
        logic       in_range;
    } req_t;

    // Number of 64-bit beats carried by a transfer of 2**size bytes.
    function automatic logic [BEAT_W-1:0] beats_from_size(input logic [2:0] size);
        if (size <= 3'd3) begin
            return BEAT_W'(1);
        end
        return BEAT_W'(1) << (size - 3'd3);
    endfunction

endpackage

// File: rtl/tl_mem_array.sv
// Byte-writable word array: one synchronous write port, one combinational read port.
module tl_mem_array
    import tl_uh_pkg::*;
#(
    parameter int unsigned WORDS     = 16384,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1,
    parameter              INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W/8-1:0] wmask,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata_c
);

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(DATA_W / 8); b++) begin
                if (wmask[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/tl_uh_mem_responder.sv
// TL-UH memory-side responder with programmable response latency.
// Define TL_MEM_BACKPRESSURE_EN to add LFSR-driven A/D backpressure.
module tl_uh_mem_responder
    import tl_uh_pkg::*;
#(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned MEM_WORDS = 16384,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int unsigned LATENCY   = 4,
    parameter              INIT_FILE = ""
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [2:0]        a_opcode_i,
    input  logic [2:0]        a_param_i,
    input  logic [2:0]        a_size_i,
    input  logic [3:0]        a_source_i,
    input  logic [ADDR_W-1:0] a_address_i,
    input  logic [7:0]        a_mask_i,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    output logic [2:0]        d_opcode_o,
    output logic [1:0]        d_param_o,
    output logic [2:0]        d_size_o,
    output logic [3:0]        d_source_o,
    output logic [1:0]        d_sink_o,
    output logic              d_denied_o,
    output logic [DATA_W-1:0] d_data_o,
    output logic              d_corrupt_o,
    output logic              d_valid_o,
    input  logic              d_ready_i
);

    localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int unsigned LAT_W = 8;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATENCY - 1);

    state_e              state_q, state_d;
    req_t                req_q, req_d;
    logic [IDX_W-1:0]    base_q, base_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [LAT_W-1:0]    lat_q, lat_d;

    logic                a_ready_q, a_ready_d;
    logic                d_valid_q, d_valid_d;
    logic [2:0]          d_opcode_q, d_opcode_d;
    logic [2:0]          d_size_q, d_size_d;
    logic [3:0]          d_source_q, d_source_d;
    logic                d_denied_q, d_denied_d;
    logic                d_corrupt_q, d_corrupt_d;
    logic [DATA_W-1:0]   d_data_q, d_data_d;

    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr, mem_raddr;
    logic [DATA_W-1:0]   mem_rdata;

    logic                a_fire, d_fire, done_a, d_hold;
    logic                stall_a, stall_d;
    logic [BEAT_W-1:0]   req_beats, cur_beats;
    logic [ADDR_W-1:0]   req_off, req_idx;
    logic                req_in_range;
    logic                unused_a_param;

    assign unused_a_param = ^a_param_i;

    assign a_fire = a_valid_i && a_ready_q;
    assign d_fire = d_valid_q && d_ready_i;

    // First-beat decode: beat count and range check against the array window.
    assign req_beats    = beats_from_size(a_size_i);
    assign cur_beats    = beats_from_size(req_q.size);
    assign req_off      = a_address_i - ADDR_W'(BASE_ADDR);
    assign req_idx      = req_off >> 3;
    assign req_in_range = (a_address_i >= ADDR_W'(BASE_ADDR)) &&
                          (req_idx + ADDR_W'(req_beats) <= ADDR_W'(MEM_WORDS));

`ifdef TL_MEM_BACKPRESSURE_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // Stalls use the next LFSR value so they line up with the registered outputs.
    assign stall_a = (lfsr_d[1:0] == 2'b00);
    assign stall_d = (lfsr_d[3:2] == 2'b00);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall_a = 1'b0;
    assign stall_d = 1'b0;
`endif

    tl_mem_array #(
        .WORDS     (MEM_WORDS),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk     (clk_i),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wmask   (a_mask_i),
        .wdata   (a_data_i),
        .raddr   (mem_raddr),
        .rdata_c (mem_rdata)
    );

    // Next-state logic and array write control.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        base_d    = base_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        mem_we    = 1'b0;
        mem_waddr = base_q + IDX_W'(beat_q);
        done_a    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (a_fire) begin
                    req_d.opcode   = a_opcode_i;
                    req_d.size     = a_size_i;
                    req_d.source   = a_source_i;
                    req_d.in_range = req_in_range;
                    req_d.denied   = !req_in_range;
                    base_d         = IDX_W'(req_idx);
                    beat_d         = '0;
                    lat_d          = '0;
                    if (a_opcode_i == PUT_FULL || a_opcode_i == PUT_PARTIAL) begin
                        mem_we    = req_in_range;
                        mem_waddr = IDX_W'(req_idx);
                        if (req_beats == BEAT_W'(1)) begin
                            done_a = 1'b1;
                        end else begin
                            beat_d  = BEAT_W'(1);
                            state_d = WBURST;
                        end
                    end else begin
                        if (a_opcode_i != GET) begin
                            req_d.denied = 1'b1;
                        end
                        done_a = 1'b1;
                    end
                end
            end
            WBURST: begin
                if (a_fire) begin
                    mem_we = req_q.in_range;
                    if (beat_q == cur_beats - BEAT_W'(1)) begin
                        beat_d = '0;
                        done_a = 1'b1;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            WAIT: begin
                if (lat_q == LAT_LAST) begin
                    lat_d   = '0;
                    state_d = RESP;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            RESP: begin
                if (d_fire) begin
                    if (req_q.opcode == GET && beat_q != cur_beats - BEAT_W'(1)) begin
                        beat_d = beat_q + BEAT_W'(1);
                    end else begin
                        beat_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (done_a) begin
            state_d = (LATENCY == 0) ? RESP : WAIT;
        end
    end

    assign mem_raddr = base_d + IDX_W'(beat_d);

    // Next values of the registered A/D outputs; a presented beat is held until it fires.
    always_comb begin
        a_ready_d   = (state_d == IDLE || state_d == WBURST) && !stall_a;
        d_hold      = d_valid_q && !d_ready_i;
        d_valid_d   = 1'b0;
        d_opcode_d  = '0;
        d_size_d    = '0;
        d_source_d  = '0;
        d_denied_d  = 1'b0;
        d_corrupt_d = 1'b0;
        d_data_d    = '0;

        if (d_hold) begin
            d_valid_d   = 1'b1;
            d_opcode_d  = d_opcode_q;
            d_size_d    = d_size_q;
            d_source_d  = d_source_q;
            d_denied_d  = d_denied_q;
            d_corrupt_d = d_corrupt_q;
            d_data_d    = d_data_q;
        end else if (state_d == RESP && !stall_d) begin
            d_valid_d   = 1'b1;
            d_opcode_d  = (req_d.opcode == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
            d_size_d    = req_d.size;
            d_source_d  = req_d.source;
            d_denied_d  = req_d.denied;
            d_corrupt_d = (req_d.opcode == GET) && req_d.denied;
            d_data_d    = (req_d.opcode == GET && !req_d.denied) ? mem_rdata : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            req_q       <= '0;
            base_q      <= '0;
            beat_q      <= '0;
            lat_q       <= '0;
            a_ready_q   <= 1'b1;
            d_valid_q   <= 1'b0;
            d_opcode_q  <= '0;
            d_size_q    <= '0;
            d_source_q  <= '0;
            d_denied_q  <= 1'b0;
            d_corrupt_q <= 1'b0;
            d_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            base_q      <= base_d;
            beat_q      <= beat_d;
            lat_q       <= lat_d;
            a_ready_q   <= a_ready_d;
            d_valid_q   <= d_valid_d;
            d_opcode_q  <= d_opcode_d;
            d_size_q    <= d_size_d;
            d_source_q  <= d_source_d;
            d_denied_q  <= d_denied_d;
            d_corrupt_q <= d_corrupt_d;
            d_data_q    <= d_data_d;
        end
    end

    assign a_ready_o   = a_ready_q;
    assign d_valid_o   = d_valid_q;
    assign d_opcode_o  = d_opcode_q;
    assign d_param_o   = 2'b00;
    assign d_size_o    = d_size_q;
    assign d_source_o  = d_source_q;
    assign d_sink_o    = 2'b00;
    assign d_denied_o  = d_denied_q;
    assign d_data_o    = d_data_q;
    assign d_corrupt_o = d_corrupt_q;

endmodule

// File: tb/tb_tl_uh_mem_responder.sv
// Scoreboard bench for tl_uh_mem_responder: randomized TL-UH traffic against
// a flat-array memory model; responses checked by an independent D monitor.
module tb_tl_uh_mem_responder;
    import tl_uh_pkg::*;

    localparam int unsigned MW   = 256;
    localparam int unsigned LAT  = 4;
    localparam logic [63:0] BASE = 64'h8000_0000;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic [3:0]  source;
        logic        denied;
        logic        corrupt;
        logic        chk_data;
        logic        first;
        logic [63:0] data;
    } exp_t;

    logic        clk, rst_n;
    logic [2:0]  a_opcode, a_param, a_size;
    logic [3:0]  a_source;
    logic [63:0] a_address, a_data;
    logic [7:0]  a_mask;
    logic        a_valid, a_ready;
    logic [2:0]  d_opcode, d_size;
    logic [1:0]  d_param, d_sink;
    logic [3:0]  d_source;
    logic        d_denied, d_corrupt, d_valid, d_ready;
    logic [63:0] d_data;

    tl_uh_mem_responder #(
        .ADDR_W(64), .DATA_W(64), .MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(LAT), .INIT_FILE("")
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .a_opcode_i(a_opcode), .a_param_i(a_param), .a_size_i(a_size), .a_source_i(a_source),
        .a_address_i(a_address), .a_mask_i(a_mask), .a_data_i(a_data), .a_valid_i(a_valid),
        .a_ready_o(a_ready),
        .d_opcode_o(d_opcode), .d_param_o(d_param), .d_size_o(d_size), .d_source_o(d_source),
        .d_sink_o(d_sink), .d_denied_o(d_denied), .d_data_o(d_data), .d_corrupt_o(d_corrupt),
        .d_valid_o(d_valid), .d_ready_i(d_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          last_fire_cyc = 0;
    int          pres_cyc = 0;
    int          beats_fired = 0;
    int          d_mode = 0;
    int          pat_idx = 0;
    exp_t        exp_q[$];
    logic [63:0] model_mem [MW];
    logic [63:0] bdata [8];
    logic [7:0]  bmask [8];

    always @(posedge clk) cyc <= cyc + 1;

    // D-ready generator: always ready, random, or the repeating 1,0,0,1 pattern.
    always @(posedge clk) begin
        logic [3:0] pat;
        pat = 4'b1001;
        #1;
        if (d_mode == 0) begin
            d_ready = 1'b1;
        end else if (d_mode == 1) begin
            d_ready = 1'($urandom_range(0, 1));
        end else begin
            d_ready = pat[pat_idx[1:0]];
            pat_idx = pat_idx + 1;
        end
    end

    // D monitor: stability while stalled, scoreboard pop on each fire, first-beat latency.
    logic        prev_v = 1'b0;
    logic        prev_stall = 1'b0;
    logic [75:0] snap = '0;
    always @(negedge clk) begin
        logic [75:0] cur;
        exp_t        e;
        int          diff;
        logic        lat_ok;
        cur = {d_opcode, d_size, d_source, d_denied, d_corrupt, d_data};
        if (!rst_n) begin
            prev_v     = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (d_valid) begin
                if (!prev_v) pres_cyc = cyc;
                if (prev_stall) begin
                    checks++;
                    if (cur !== snap) begin
                        errors++;
                        $display("FAIL d_stable actual=%h required=%h", cur, snap);
                    end
                end
                if (d_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL d_unexpected actual beat op=%0d src=%0d required none", d_opcode, d_source);
                    end else begin
                        e = exp_q.pop_front();
                        beats_fired++;
                        if (d_opcode !== e.opcode || d_size !== e.size || d_source !== e.source ||
                            d_denied !== e.denied || d_corrupt !== e.corrupt ||
                            (e.chk_data && d_data !== e.data)) begin
                            errors++;
                            $display("FAIL d_beat actual op=%0d size=%0d src=%0d den=%0d cor=%0d data=%h required op=%0d size=%0d src=%0d den=%0d cor=%0d data=%h",
                                     d_opcode, d_size, d_source, d_denied, d_corrupt, d_data,
                                     e.opcode, e.size, e.source, e.denied, e.corrupt, e.data);
                        end
                        if (e.first) begin
                            diff = pres_cyc - last_fire_cyc;
`ifdef TL_MEM_BACKPRESSURE_EN
                            lat_ok = (diff >= int'(LAT) + 1);
`else
                            lat_ok = (diff == int'(LAT) + 1);
`endif
                            checks++;
                            if (!lat_ok) begin
                                errors++;
                                $display("FAIL d_latency actual=%0d required=%0d", diff - 1, LAT);
                            end
                        end
                    end
                end
            end
            prev_v     = d_valid;
            prev_stall = d_valid && !d_ready;
            snap       = cur;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Present one A beat (entered just after a posedge) and return just after it fires.
    task automatic drive_beat(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                              input logic [63:0] addr, input logic [7:0] mask, input logic [63:0] data);
        int n;
        n = 0;
        a_opcode  = op;
        a_param   = 3'($urandom_range(0, 7));
        a_size    = sz;
        a_source  = src;
        a_address = addr;
        a_mask    = mask;
        a_data    = data;
        a_valid   = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!a_ready && n < 500);
        if (!a_ready) begin
            checks++;
            errors++;
            $display("FAIL a_accept_timeout actual=0 required=1");
        end
        last_fire_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL d_timeout actual=%0d pending required=0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    // Model the request, queue its expected D beats, then drive the A beats.
    task automatic issue(input logic [2:0] op, input logic [2:0] sz, input logic [3:0] src,
                         input logic [63:0] addr, input bit wait_resp);
        logic [63:0] nb, idx;
        logic        ok;
        exp_t        e;
        nb  = (sz <= 3'd3) ? 64'd1 : (64'd1 << (sz - 3'd3));
        idx = (addr - BASE) >> 3;
        ok  = (addr >= BASE) && (idx + nb <= 64'(MW));
        e        = '0;
        e.size   = sz;
        e.source = src;
        e.first  = 1'b1;
        @(posedge clk);
        #1;
        if (op == PUT_FULL || op == PUT_PARTIAL) begin
            if (ok) begin
                for (int i = 0; i < int'(nb); i++)
                    for (int b = 0; b < 8; b++)
                        if (bmask[i][b]) model_mem[idx + 64'(i)][8*b +: 8] = bdata[i][8*b +: 8];
            end
            e.opcode = ACCESS_ACK;
            e.denied = !ok;
            exp_q.push_back(e);
            for (int i = 0; i < int'(nb); i++) drive_beat(op, sz, src, addr, bmask[i], bdata[i]);
        end else if (op == GET) begin
            for (int i = 0; i < int'(nb); i++) begin
                e.opcode   = ACCESS_ACK_DATA;
                e.denied   = !ok;
                e.corrupt  = !ok;
                e.chk_data = 1'b1;
                e.first    = (i == 0);
                if (ok) e.data = model_mem[idx + 64'(i)];
                else    e.data = 64'd0;
                exp_q.push_back(e);
            end
            drive_beat(op, sz, src, addr, 8'hFF, 64'd0);
        end else begin
            e.opcode = ACCESS_ACK;
            e.denied = 1'b1;
            exp_q.push_back(e);
            drive_beat(op, sz, src, addr, 8'hFF, 64'd0);
        end
        a_valid = 1'b0;
        if (wait_resp) wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op, sz;
        logic [63:0] addr;
        int          r, n;
        rst_n = 1'b0;
        a_valid = 1'b0; a_opcode = '0; a_param = '0; a_size = '0; a_source = '0;
        a_address = '0; a_mask = '0; a_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_a_ready", 64'(a_ready), 64'd1);
        chk("rst_d_valid", 64'(d_valid), 64'd0);
        chk("rst_d_fields", {53'd0, d_opcode, d_size, d_source, d_denied}, 64'd0);
        chk("rst_d_data", d_data, 64'd0);
        rst_n = 1'b1;

        // Fill the whole array so every later read has a known model value.
        d_mode = 0;
        for (int k = 0; k < int'(MW / 8); k++) begin
            for (int i = 0; i < 8; i++) begin
                bdata[i] = {$urandom, $urandom};
                bmask[i] = 8'hFF;
            end
            issue(PUT_FULL, 3'd6, 4'(k), BASE + 64'(k) * 64, 1'b1);
        end

        for (int i = 0; i < 8; i++) begin
            bdata[i] = 64'(32'h1111 * (i + 1)) << 32;
            bmask[i] = 8'hFF;
        end
        issue(PUT_FULL, 3'd6, 4'd5, 64'h8000_0040, 1'b1);
        issue(GET, 3'd6, 4'd6, 64'h8000_0040, 1'b1);
        bdata[0] = 64'hDEADBEEF_CAFEBABE;
        bmask[0] = 8'h0F;
        issue(PUT_PARTIAL, 3'd3, 4'd7, 64'h8000_0040, 1'b1);
        issue(GET, 3'd3, 4'd8, 64'h8000_0040, 1'b1);

        d_mode = 2;
        issue(GET, 3'd6, 4'd9, 64'h8000_0040, 1'b1);
        d_mode = 0;

        // Range boundaries and error responses.
        issue(GET, 3'd6, 4'd10, 64'h7FFF_FFC0, 1'b1);
        bdata[0] = 64'h0123_4567_89AB_CDEF;
        bmask[0] = 8'hFF;
        issue(PUT_FULL, 3'd3, 4'd11, BASE + 64'(MW) * 8, 1'b1);
        issue(GET, 3'd3, 4'd12, BASE + 64'(MW - 1) * 8, 1'b1);
        issue(GET, 3'd6, 4'd13, BASE + 64'(MW - 8) * 8, 1'b1);
        issue(GET, 3'd6, 4'd14, BASE + 64'(MW - 7) * 8, 1'b1);
        issue(3'd2, 3'd3, 4'd15, BASE, 1'b1);
        issue(GET, 3'd0, 4'd3, BASE + 64'h13, 1'b1);

        d_mode = 1;
        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 2)      op = PUT_FULL;
            else if (r <= 4) op = PUT_PARTIAL;
            else if (r <= 8) op = GET;
            else             op = 3'($urandom_range(2, 3));
            sz = 3'($urandom_range(0, 6));
            if ($urandom_range(0, 9) == 0) addr = BASE - 64'($urandom_range(1, 128));
            else addr = BASE + 64'($urandom_range(0, MW + 4)) * 8 + 64'($urandom_range(0, 7));
            for (int i = 0; i < 8; i++) begin
                bdata[i] = {$urandom, $urandom};
                bmask[i] = (op == PUT_FULL) ? 8'hFF : 8'($urandom);
            end
            issue(op, sz, 4'($urandom), addr, 1'b1);
        end

        // Reset in the middle of a Get burst, then a normal Get.
        d_mode = 0;
        beats_fired = 0;
        issue(GET, 3'd6, 4'd2, BASE + 64'h80, 1'b0);
        n = 0;
        while (beats_fired < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("beats_before_reset", 64'(beats_fired >= 3), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_d_valid", 64'(d_valid), 64'd0);
        chk("mid_rst_a_ready", 64'(a_ready), 64'd1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(GET, 3'd6, 4'd4, BASE + 64'h80, 1'b1);
        issue(GET, 3'd6, 4'd1, 64'h8000_0040, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
